// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the local-memory responder: transfer/size
// encodings, response codes, responder FSM states and the byte-lane helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    SLV_IDLE = 3'd0,
    SLV_WAIT = 3'd1,
    SLV_DATA = 3'd2,
    SLV_ERR1 = 3'd3,
    SLV_ERR2 = 3'd4
  } slv_state_t;

  // Little-endian byte-lane strobes for a legal (aligned) transfer.
  function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] strb;
    strb = 4'b0000;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr;
      HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: strb = 4'b1111;
      default:    strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// DEPTH x 32 word storage: per-byte write enables, combinational read port.
// No reset: contents survive hreset.
module ahb_slave_mem_array #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write; unselected lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder in front of a word-organised local memory.
// Optional feature macro: AHB_SLV_WAIT_EN -- when defined, every legal
// transfer inserts WAIT_CYCLES wait states before its completing cycle;
// when undefined the wait state and its counter do not exist.
//
// Handshake: an address phase is taken at a rising edge when
// hsel & hready & (htrans is NONSEQ or SEQ). The resulting data phase holds
// hreadyout low until its last cycle; the cycle with hreadyout=1 completes
// it, and a new address phase may be taken at that same edge.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  slv_state_t       state_q, state_d;
  logic [IDX_W+1:0] addr_q;
  logic             write_q;
  logic [2:0]       size_q;
  logic             valid_q;

  htrans_t          trans;
  logic             accept;
  logic             legal;
  logic [31:0]      offset;
  logic [3:0]       we;
  logic [31:0]      rdata;

`ifdef AHB_SLV_WAIT_EN
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
  logic [2:0] wait_q, wait_d;
`else
  logic unused_wait;
  assign unused_wait = ^3'(WAIT_CYCLES);
`endif

  assign trans  = htrans_t'(htrans);
  assign accept = hsel && hready && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
  assign offset = haddr - BASE_ADDR;

  // Address-phase legality: size, alignment and range (below-base wraps high).
  always_comb begin
    legal = 1'b1;
    if (hsize > 3'b010) legal = 1'b0;
    if (hsize == 3'b001 && haddr[0]) legal = 1'b0;
    if (hsize == 3'b010 && haddr[1:0] != 2'b00) legal = 1'b0;
    if (offset >= SPAN) legal = 1'b0;
  end

  // Next state and data-phase response.
  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
`ifdef AHB_SLV_WAIT_EN
    wait_d    = wait_q;
`endif
    case (state_q)
`ifdef AHB_SLV_WAIT_EN
      SLV_WAIT: begin
        hreadyout = 1'b0;
        if (wait_q <= 3'd1) state_d = SLV_DATA;
        else                wait_d  = wait_q - 3'd1;
      end
`endif
      SLV_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = SLV_ERR2;
      end
      default: begin
        // IDLE, DATA or ERR2: any current data phase ends this cycle.
        if (state_q == SLV_ERR2) hresp = HRESP_ERROR;
        if (accept) begin
          if (!legal) begin
            state_d = SLV_ERR1;
          end else begin
`ifdef AHB_SLV_WAIT_EN
            if (WAIT_INIT != 3'd0) begin
              state_d = SLV_WAIT;
              wait_d  = WAIT_INIT;
            end else begin
              state_d = SLV_DATA;
            end
`else
            state_d = SLV_DATA;
`endif
          end
        end else begin
          state_d = SLV_IDLE;
        end
      end
    endcase
  end

  // State and address-phase capture registers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= SLV_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      valid_q <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef AHB_SLV_WAIT_EN
      wait_q  <= wait_d;
`endif
      if (hreadyout && accept) begin
        addr_q  <= offset[IDX_W+1:0];
        write_q <= hwrite;
        size_q  <= hsize;
        valid_q <= legal;
      end else if (hreadyout) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Write commits at the edge closing DATA; a reset at that edge abandons it.
  assign we = (state_q == SLV_DATA && valid_q && write_q && !hreset)
              ? lane_strb(size_q, addr_q[1:0]) : 4'b0000;

  assign hrdata = (state_q == SLV_DATA && !write_q) ? rdata : 32'h0;

  ahb_slave_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk   (hclk),
    .we    (we),
    .waddr (addr_q[IDX_W+1:2]),
    .wdata (hwdata),
    .raddr (addr_q[IDX_W+1:2]),
    .rdata (rdata)
  );

endmodule
